// File: rtl/riego_pkg.sv
// ---------------------------------------------------------------------------
// riego_pkg
// Shared constants for the irrigation pump scheduler: FSM state codes, tank
// level codes, valve request codes and status codes, plus a small helper that
// turns a zone index into its one-hot grant vector.
// ---------------------------------------------------------------------------
package riego_pkg;

    // Scheduler states. These are kept as plain 2-bit constants so that older
    // blocks in the codebase can compare against them directly.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    // Tank level as reported by the level sensor.
    localparam logic [1:0] LVL_EMPTY = 2'b00;
    localparam logic [1:0] LVL_LOW   = 2'b01;
    localparam logic [1:0] LVL_OK    = 2'b10;
    localparam logic [1:0] LVL_FULL  = 2'b11;

    // Per-zone valve request / enable codes.
    localparam logic [1:0] V_NONE = 2'b00;
    localparam logic [1:0] V_A    = 2'b01;
    localparam logic [1:0] V_B    = 2'b10;
    localparam logic [1:0] V_AB   = 2'b11;

    // Status reported on E.
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_LOW = 2'b01;
    localparam logic [1:0] ST_DRY = 2'b10;

    // Zone index 0 is zone1, 1 is zone2; grant vector is {z2,z1}.
    function automatic logic [1:0] zone_onehot(input logic zone);
        return zone ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/riego_slot_timer.sv
// ---------------------------------------------------------------------------
// riego_slot_timer
// Loadable down-counter shared by the RUN slot and the GAP settle period.
// It saturates at zero instead of wrapping.
// Ports:
//   clk       in  1  clock
//   reset     in  1  synchronous active-high reset (count -> 0)
//   load      in  1  load load_val this cycle (wins over en)
//   load_val  in  W  value to load
//   en        in  1  decrement by one when non-zero
//   zero      out 1  count is zero
// ---------------------------------------------------------------------------
module riego_slot_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/riego_scheduler.sv
// ---------------------------------------------------------------------------
// riego_scheduler
// Shares one irrigation pump between two zones. One zone at a time is granted
// for at most SLOT_CYCLES cycles, round-robin when both request, with a
// GAP_CYCLES all-closed settle period after every slot. An empty tank forces
// a dry fault that only clears once the level is back to ok or full.
// All outputs are decoded from registered state only.
// Ports:
//   clk    in  1  clock
//   reset  in  1  synchronous active-high reset
//   G1     in  2  zone1 valve request (00 none, 01 a, 10 b, 11 both)
//   G2     in  2  zone2 valve request, same encoding
//   A      in  2  tank level (00 empty, 01 low, 10 ok, 11 full)
//   R1     out 2  zone1 valve enables
//   R2     out 2  zone2 valve enables
//   P      out 1  pump enable
//   gnt    out 2  one-hot granted zone {z2,z1}, 00 when none
//   E      out 2  status (00 ok, 01 low, 10 dry fault)
// ---------------------------------------------------------------------------
module riego_scheduler
    import riego_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] G1,
    input  logic [1:0] G2,
    input  logic [1:0] A,
    output logic [1:0] R1,
    output logic [1:0] R2,
    output logic       P,
    output logic [1:0] gnt,
    output logic [1:0] E
);

    localparam int unsigned MAX_CYC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    // Timer is loaded with N-1 so the state lasts exactly N cycles.
    localparam logic [TW-1:0] SLOT_LOAD = TW'(SLOT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    // Registered state
    logic [1:0] state;
    logic [1:0] mask;     // valve request latched at grant time
    logic       zone;     // granted zone: 0 = zone1, 1 = zone2
    logic       rr;       // zone that wins when both request
    logic       low_q;    // tank was low at the last edge

    // Next-state values
    logic [1:0] state_n;
    logic [1:0] mask_n;
    logic       zone_n;
    logic       rr_n;

    // Timer control
    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_en;
    logic          t_zero;

    // Live request of the zone currently holding the pump; used only to detect
    // an early release, the valve pattern itself stays frozen in mask.
    logic [1:0] granted_req;
    assign granted_req = zone ? G2 : G1;

    riego_slot_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .zero     (t_zero)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        mask_n  = mask;
        zone_n  = zone;
        rr_n    = rr;
        t_load  = 1'b0;
        t_val   = '0;
        t_en    = 1'b0;

        case (state)
            S_IDLE: begin
                if (A == LVL_EMPTY) begin
                    state_n = S_FAULT;
                end else if (A == LVL_LOW) begin
                    state_n = S_IDLE;   // new grants inhibited while low
                end else if ((G1 != V_NONE) || (G2 != V_NONE)) begin
                    // Zone1 wins if it is the sole requester or holds the pointer.
                    if ((G1 != V_NONE) && ((G2 == V_NONE) || (rr == 1'b0))) begin
                        zone_n = 1'b0;
                        mask_n = G1;
                    end else begin
                        zone_n = 1'b1;
                        mask_n = G2;
                    end
                    state_n = S_RUN;
                    t_load  = 1'b1;
                    t_val   = SLOT_LOAD;
                end
            end

            S_RUN: begin
                if (A == LVL_EMPTY) begin
                    state_n = S_FAULT;
                    rr_n    = ~zone;
                end else if ((granted_req == V_NONE) || t_zero) begin
                    state_n = S_GAP;
                    rr_n    = ~zone;
                    t_load  = 1'b1;
                    t_val   = GAP_LOAD;
                end else begin
                    t_en = 1'b1;
                end
            end

            S_GAP: begin
                if (A == LVL_EMPTY) begin
                    state_n = S_FAULT;
                end else if (t_zero) begin
                    state_n = S_IDLE;
                end else begin
                    t_en = 1'b1;
                end
            end

            S_FAULT: begin
                // Hysteresis: only ok or full clears the fault, low does not.
                if (A[1]) begin
                    state_n = S_GAP;
                    t_load  = 1'b1;
                    t_val   = GAP_LOAD;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            mask  <= V_NONE;
            zone  <= 1'b0;
            rr    <= 1'b0;
            low_q <= 1'b0;
        end else begin
            state <= state_n;
            mask  <= mask_n;
            zone  <= zone_n;
            rr    <= rr_n;
            low_q <= (A == LVL_LOW);
        end
    end

    // Moore output decode; anything other than RUN keeps valves and pump shut.
    always_comb begin
        R1  = V_NONE;
        R2  = V_NONE;
        P   = 1'b0;
        gnt = 2'b00;
        if (state == S_RUN) begin
            P   = 1'b1;
            gnt = zone_onehot(zone);
            if (zone) begin
                R2 = mask;
            end else begin
                R1 = mask;
            end
        end
        if (state == S_FAULT) begin
            E = ST_DRY;
        end else if (low_q) begin
            E = ST_LOW;
        end else begin
            E = ST_OK;
        end
    end

endmodule
